// File: rtl/cache_2way_ctrl.sv
// 2-way set-associative data cache controller: tags/valid/LRU held here,
// data in two external sync-read RAMs; read-miss fill, write-hit RMW merge, write-through.
module cache_2way_ctrl #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 8,
  parameter int DWIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [TWIDTH+AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0]        req_wdata,
  input  logic [DWIDTH/8-1:0]      req_be,
  output logic                     rsp_valid,
  output logic [DWIDTH-1:0]        rsp_rdata,
  output logic                     rsp_hit,
  output logic [AWIDTH-1:0]        ram_addr,
  output logic [DWIDTH-1:0]        ram_din,
  output logic                     ram_we0,
  output logic                     ram_we1,
  input  logic [DWIDTH-1:0]        ram_dout0,
  input  logic [DWIDTH-1:0]        ram_dout1,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [TWIDTH+AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0]        mem_wdata,
  output logic [DWIDTH/8-1:0]      mem_be,
  input  logic                     mem_ack,
  input  logic [DWIDTH-1:0]        mem_rdata
);
  localparam int BW    = DWIDTH / 8;
  localparam int DEPTH = 1 << AWIDTH;
  localparam int ALEN  = TWIDTH + AWIDTH;

  typedef enum logic [2:0] {IDLE, LOOKUP, MERGE, MEMWR, FILL, RESP} state_t;

  state_t              state;
  logic [ALEN-1:0]     addr_q;
  logic                we_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [BW-1:0]       be_q;
  logic [DEPTH-1:0]    valid0, valid1, lru;
  logic [TWIDTH-1:0]   tag0 [DEPTH];
  logic [TWIDTH-1:0]   tag1 [DEPTH];
  logic [DWIDTH-1:0]   din_q;
  logic                merge_we0, merge_we1;

  logic [AWIDTH-1:0]   idx;
  logic [TWIDTH-1:0]   tag;
  logic                hit0, hit1, victim, fill_we;
  logic [DWIDTH-1:0]   hit_data, merged;

  assign idx      = addr_q[AWIDTH-1:0];
  assign tag      = addr_q[ALEN-1:AWIDTH];
  assign hit0     = valid0[idx] && (tag0[idx] == tag);
  assign hit1     = valid1[idx] && (tag1[idx] == tag);
  assign hit_data = hit0 ? ram_dout0 : ram_dout1;
  // lru[idx] names the way to evict once both ways are valid
  assign victim   = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);
  assign fill_we  = (state == FILL) && mem_ack;

  always_comb begin
    merged = hit_data;
    for (int unsigned i = 0; i < BW; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Fill write must land in the ack cycle, so the fill path bypasses the registers
  assign ram_we0   = merge_we0 | (fill_we & ~victim);
  assign ram_we1   = merge_we1 | (fill_we & victim);
  assign ram_din   = fill_we ? mem_rdata : din_q;
  assign ram_addr  = (state == IDLE) ? req_addr[AWIDTH-1:0] : idx;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_req   = (state == MEMWR) || (state == FILL);
  assign mem_we    = (state == MEMWR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      valid0    <= '0;
      valid1    <= '0;
      lru       <= '0;
      din_q     <= '0;
      merge_we0 <= 1'b0;
      merge_we1 <= 1'b0;
      rsp_rdata <= '0;
      rsp_hit   <= 1'b0;
    end else begin
      merge_we0 <= 1'b0;
      merge_we1 <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          we_q    <= req_we;
          wdata_q <= req_wdata;
          be_q    <= req_be;
          state   <= LOOKUP;
        end
        LOOKUP: begin
          if (we_q) begin
            rsp_rdata <= '0;
            rsp_hit   <= hit0 | hit1;
            if (hit0 | hit1) begin
              din_q     <= merged;
              merge_we0 <= hit0;
              merge_we1 <= ~hit0;
              state     <= MERGE;
            end else begin
              state <= MEMWR;
            end
          end else if (hit0 | hit1) begin
            rsp_rdata <= hit_data;
            rsp_hit   <= 1'b1;
            lru[idx]  <= hit0;
            state     <= RESP;
          end else begin
            state <= FILL;
          end
        end
        MERGE: begin
          lru[idx] <= ~merge_we1;
          state    <= MEMWR;
        end
        MEMWR: if (mem_ack) state <= RESP;
        FILL: if (mem_ack) begin
          if (victim) begin
            tag1[idx]   <= tag;
            valid1[idx] <= 1'b1;
          end else begin
            tag0[idx]   <= tag;
            valid0[idx] <= 1'b1;
          end
          lru[idx]  <= ~victim;
          rsp_rdata <= mem_rdata;
          rsp_hit   <= 1'b0;
          state     <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cache_2way_ctrl.md
Name: cache_2way_ctrl

Overview:
Controller for the 2-way set-associative data cache. It sequences the two synchronous-read data RAM instances (way 0, way 1), which share one address bus and have separate write enables. It holds the tag, valid and LRU state internally and performs byte-enabled write-hit merges as read-modify-write. It handles read-miss fills and write-through to memory over a req/ack handshake.

Parameters:
AWIDTH, 3, set-index width; also the address width of each data RAM (DEPTH = 1<<AWIDTH sets).
TWIDTH, 8, tag width.
DWIDTH, 32, data word width; must be a multiple of 8.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  CPU request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  TWIDTH+AWIDTH  word address {tag, index}
req_wdata  in  DWIDTH  write data
req_be  in  DWIDTH/8  byte enables; bit i covers bits [8i+7:8i]
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  DWIDTH  read data; 0 for writes
rsp_hit  out  1  request hit in cache
ram_addr  out  AWIDTH  shared address to both data RAMs
ram_din  out  DWIDTH  shared write data to both RAMs
ram_we0  out  1  write enable, way 0 RAM
ram_we1  out  1  write enable, way 1 RAM
ram_dout0  in  DWIDTH  way 0 RAM read data (1-cycle sync read)
ram_dout1  in  DWIDTH  way 1 RAM read data
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write (write-through)
mem_addr  out  TWIDTH+AWIDTH  memory word address
mem_wdata  out  DWIDTH  memory write data
mem_be  out  DWIDTH/8  memory byte enables
mem_ack  in  1  one-cycle completion; mem_rdata valid with it on reads
mem_rdata  in  DWIDTH  fill data

Behaviour:
- Reset: state IDLE. All valid bits = 0 and all LRU bits = 0; tags are don't-care. Outputs: req_ready=1; rsp_valid, rsp_hit, ram_we0/1, mem_req and mem_we = 0; data and address outputs = 0.
- Reset mid-operation (any state): abandons the transaction with no response. mem_req drops the cycle after reset is sampled. The memory side must tolerate a dropped request.
- ram_addr = req_addr index while in IDLE; otherwise the latched index. RAM read data is therefore valid in LOOKUP.
- IDLE: req_ready=1. When req_valid is high, latch addr, we, wdata and be, then go to LOOKUP. req_ready=0 in every other state.
- LOOKUP: hitN = validN[idx] & (tagN[idx] == latched tag). If both ways hit, way 0 wins.
  - Read hit: rsp_rdata = hit-way dout, rsp_hit=1, lru[idx] = ~hitway; go to RESP.
  - Read miss: go to FILL.
  - Write hit: go to MERGE.
  - Write miss: go to MEMWR with rsp_hit=0; no RAM write and no allocation.
- MERGE (1 cycle): ram_din byte i = be[i] ? wdata byte i : old byte i. The hit way's ram_we pulses. lru[idx] = ~hitway, rsp_hit=1; go to MEMWR. be=0 still writes the unchanged word.
- MEMWR: mem_req=1, mem_we=1, mem_addr, mem_wdata and mem_be taken from the latched request. On mem_ack, go to RESP.
- FILL: mem_req=1, mem_we=0. On mem_ack:
  - Victim = way 0 if !valid0, else way 1 if !valid1, else lru[idx].
  - ram_din = mem_rdata and the victim's ram_we pulses in that same cycle.
  - Set tag and valid for the victim; lru[idx] = ~victim.
  - rsp_rdata = mem_rdata, rsp_hit=0; go to RESP.
- RESP: rsp_valid=1 for exactly one cycle; go to IDLE.
- Latency with acceptance at cycle T:
  - Read hit: rsp_valid at T+2.
  - Write hit: mem_req at T+3.
  - Miss: mem_req at T+2; rsp_valid 1 cycle after mem_ack.
- mem_ack outside MEMWR/FILL is ignored. Index wrap: no cross-set effects.

Test Plan:
1. Reset, read 0x015 (tag 0x02, set 5) -> mem_req=1, mem_we=0, mem_addr=0x015. Ack with 0xDEADBEEF after 3 cycles -> ram_we0 pulse at addr 5; rsp_valid with rdata 0xDEADBEEF, hit=0.
2. Re-read 0x015 -> rsp_valid exactly 2 cycles after acceptance, hit=1, rdata 0xDEADBEEF, no mem_req.
3. Write 0x015, be=4'b0010, wdata 0x0000AA00 -> ram_we0 with ram_din 0xDEADAAEF; then mem_we=1 with mem_be=0010; rsp hit=1. A following read returns 0xDEADAAEF.
4. Read-miss 0x01D (tag 3, set 5) fills way 1. Hit it again (lru=0). Read-miss 0x025 (tag 4) fills way 0 (ram_we0). Read 0x015 -> miss.
5. Write miss 0x7F0 -> no ram_we, mem write issued, rsp hit=0, rdata=0. A following read of 0x7F0 misses.
6. Assert reset during FILL before ack -> mem_req=0 next cycle, req_ready=1, no rsp_valid. A following read of a previously filled address misses.
